// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory responder for the controller load/store port.
//               A DEPTH x NBITS storage array is accessed through a
//               three-state handshake (IDLE -> WAIT -> DONE).
//               The handshake inserts LATENCY wait cycles per access and
//               stalls the initiator through busy.
// Ports       : clock      - system clock, rising edge
//               reset      - asynchronous, active-high reset
//               MemRead    - read request, held until busy is low
//               MemWrite   - write request, held until busy is low
//               Address    - byte address (word index = Address[NBITS-1:2])
//               WriteData  - store data
//               busy       - responder occupied, initiator must stall
//               ReadData   - registered load result
//               error      - one-cycle pulse when read and write collide
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int NBITS   = 8,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [NBITS-1:0] Address,
    input  logic [NBITS-1:0] WriteData,
    output logic             busy,
    output logic [NBITS-1:0] ReadData,
    output logic             error
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Address is widened so the index slice is always in range, even when
    // the array is deeper than the address can reach.
    localparam int EXTW = ((IDXW + 2) > NBITS) ? (IDXW + 2) : NBITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NBITS-1:0]  wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [NBITS-1:0]  rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_we;

    logic [NBITS-1:0]  mem [DEPTH];

    logic [EXTW-1:0]   ext_addr;
    logic [IDXW-1:0]   word_idx;
    logic              unused_addr;
    logic              req;

    // Byte offset bits are dropped; bits above the index wrap silently.
    assign ext_addr    = EXTW'(Address);
    assign word_idx    = ext_addr[IDXW+1:2];
    assign unused_addr = ^ext_addr;
    assign req         = MemRead | MemWrite;

    // busy must rise in the request cycle itself so the controller stalls
    // without a bubble; gating with reset makes it drop asynchronously.
    assign busy = ~reset & (((state_q == ST_IDLE) & req) | (state_q == ST_WAIT));

    assign ReadData = rdata_q;
    assign error    = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                    idx_d   = word_idx;
                    wdata_d = WriteData;
                    // A colliding request resolves as a write.
                    is_wr_d = MemWrite;
                    err_d   = MemRead & MemWrite;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_DONE;
                    if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                end
            end
            ST_DONE: begin
                // Request inputs here belong to the access just finished.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset. A reset during WAIT forces IDLE at
    // once, so mem_we can never fire for an aborted write.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. A LATENCY=2
//               instance is compared every cycle against a transaction-level
//               model. LATENCY=1 and LATENCY=15 instances get directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset = 1'b1;

    // LATENCY=2 instance
    logic       MemRead = 1'b0, MemWrite = 1'b0;
    logic [7:0] Address = 8'h00, WriteData = 8'h00;
    logic       busy, error;
    logic [7:0] ReadData;
    // LATENCY=1 instance
    logic       r1 = 1'b0, w1 = 1'b0;
    logic [7:0] a1 = 8'h00, d1 = 8'h00;
    logic       b1, e1;
    logic [7:0] q1;
    // LATENCY=15 instance
    logic       r15 = 1'b0, w15 = 1'b0;
    logic [7:0] a15 = 8'h00, d15 = 8'h00;
    logic       b15, e15;
    logic [7:0] q15;

    data_mem_responder #(.NBITS(8), .DEPTH(64), .LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .busy(busy),
        .ReadData(ReadData), .error(error));

    data_mem_responder #(.NBITS(8), .DEPTH(64), .LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset), .MemRead(r1), .MemWrite(w1),
        .Address(a1), .WriteData(d1), .busy(b1), .ReadData(q1), .error(e1));

    data_mem_responder #(.NBITS(8), .DEPTH(64), .LATENCY(15)) u_lat15 (
        .clock(clock), .reset(reset), .MemRead(r15), .MemWrite(w15),
        .Address(a15), .WriteData(d15), .busy(b15), .ReadData(q15), .error(e15));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model of the LATENCY=2 instance: an accepted access
    // is in flight for LAT edges, its effect lands on the last of them, and
    // one idle-looking completion cycle follows.
    // ------------------------------------------------------------------
    logic [7:0] mem_m [0:63];
    bit         m_inflight = 1'b0;
    bit         m_done     = 1'b0;
    int         m_age      = 0;
    logic [5:0] m_idx      = 6'd0;
    logic [7:0] m_data     = 8'h00;
    bit         m_kw       = 1'b0;
    logic [7:0] m_rd       = 8'h00;
    logic       m_err      = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_inflight = 1'b0;
            m_done     = 1'b0;
            m_rd       = 8'h00;
            m_err      = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_inflight) begin
                m_age++;
                if (m_age == LAT) begin
                    if (m_kw) mem_m[m_idx] = m_data;
                    else      m_rd = mem_m[m_idx];
                    m_inflight = 1'b0;
                    m_done     = 1'b1;
                end
            end else if (MemRead || MemWrite) begin
                m_inflight = 1'b1;
                m_age      = 0;
                m_idx      = Address[7:2];
                m_data     = WriteData;
                m_kw       = MemWrite;
                m_err      = MemRead && MemWrite;
            end
        end
    end

    always @(negedge clock) begin
        logic eb;
        if (chk_en) begin
            eb = m_inflight ? 1'b1 : (m_done ? 1'b0 : (!reset && (MemRead || MemWrite)));
            check("busy", {31'd0, busy}, {31'd0, eb});
            check("ReadData", {24'd0, ReadData}, {24'd0, m_rd});
            check("error", {31'd0, error}, {31'd0, m_err});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; w selects the instance by its latency (1, 2, 15).
    // ------------------------------------------------------------------
    task automatic drive(input int w, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
        case (w)
            1:       begin r1 = rd;  w1 = wr;  a1 = a;  d1 = d;  end
            15:      begin r15 = rd; w15 = wr; a15 = a; d15 = d; end
            default: begin MemRead = rd; MemWrite = wr; Address = a; WriteData = d; end
        endcase
    endtask

    function automatic logic [9:0] sel_out(input int w);
        case (w)
            1:       return {b1, e1, q1};
            15:      return {b15, e15, q15};
            default: return {busy, error, ReadData};
        endcase
    endfunction

    // Issues one access; optionally disturbs Address/WriteData right after
    // the accept edge. Returns busy cycles, DONE-cycle ReadData, error pulses.
    task automatic access(input int w, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] d, input bit chg,
                          output int nbusy, output logic [7:0] rdata, output int nerr);
        logic [9:0] o;
        bit done;
        done  = 1'b0;
        nbusy = 0;
        nerr  = 0;
        rdata = 8'h00;
        drive(w, rd, wr, a, d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            o = sel_out(w);
            if (o[8]) nerr++;
            if (!o[9]) begin
                rdata = o[7:0];
                done  = 1'b1;
                break;
            end
            nbusy++;
            if (chg && i == 0) begin
                @(posedge clock);
                #1 drive(w, rd, wr, a + 8'h04, ~d);
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access timeout: busy never dropped (instance %0d)", w);
        end
        @(posedge clock);
        #1 drive(w, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb, ne, nlow, first, prev;
        logic [7:0] rd;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ReadData", {24'd0, ReadData}, 32'd0);
        check("reset error", {31'd0, error}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Basic write then read
        access(2, 1'b0, 1'b1, 8'h08, 8'hA5, 1'b0, nb, rd, ne);
        check("wr08 busy cycles", nb, 3);
        check("wr08 error", ne, 0);
        access(2, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, nb, rd, ne);
        check("rd08 busy cycles", nb, 3);
        check("rd08 data", {24'd0, rd}, 32'hA5);

        // Aliasing: low address bits ignored, top word reachable
        access(2, 1'b0, 1'b1, 8'h04, 8'h3C, 1'b0, nb, rd, ne);
        access(2, 1'b1, 1'b0, 8'h07, 8'h00, 1'b0, nb, rd, ne);
        check("rd07 alias", {24'd0, rd}, 32'h3C);
        access(2, 1'b0, 1'b1, 8'hFC, 8'h11, 1'b0, nb, rd, ne);
        access(2, 1'b1, 1'b0, 8'hFC, 8'h00, 1'b0, nb, rd, ne);
        check("rdFC data", {24'd0, rd}, 32'h11);

        // Read held continuously: one completion every LAT+2 cycles
        drive(2, 1'b1, 1'b0, 8'h08, 8'h00);
        nlow  = 0;
        first = -1;
        prev  = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (!busy) begin
                if (nlow == 0) first = i;
                else           check("held spacing", i - prev, 4);
                check("held data", {24'd0, ReadData}, 32'hA5);
                prev = i;
                nlow++;
            end
        end
        check("held done count", nlow, 3);
        check("held first done", first, 3);
        @(posedge clock);
        #1 drive(2, 1'b0, 1'b0, 8'h00, 8'h00);

        // Colliding request resolves as write and pulses error
        access(2, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, nb, rd, ne);
        check("collide error pulses", ne, 1);
        access(2, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, nb, rd, ne);
        check("rd10 after collide", {24'd0, rd}, 32'h5A);

        // Reset during WAIT aborts the pending write
        access(2, 1'b0, 1'b1, 8'h20, 8'h77, 1'b0, nb, rd, ne);
        drive(2, 1'b0, 1'b1, 8'h20, 8'hFF);
        @(posedge clock);
        #3 reset = 1'b1;
        #1 check("busy async drop", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1 drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clock);
        #1 reset = 1'b0;
        check("ReadData after reset", {24'd0, ReadData}, 32'd0);
        access(2, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, nb, rd, ne);
        check("rd20 after abort", {24'd0, rd}, 32'h77);

        // Inputs disturbed mid-WAIT: latched copy wins
        access(2, 1'b0, 1'b1, 8'h30, 8'h3A, 1'b1, nb, rd, ne);
        access(2, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, nb, rd, ne);
        check("rd30 latched", {24'd0, rd}, 32'h3A);

        // LATENCY=1 build
        access(1, 1'b0, 1'b1, 8'h0C, 8'hC3, 1'b1, nb, rd, ne);
        check("lat1 write busy", nb, 2);
        access(1, 1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, nb, rd, ne);
        check("lat1 read busy", nb, 2);
        check("lat1 read data", {24'd0, rd}, 32'hC3);

        // LATENCY=15 build
        access(15, 1'b0, 1'b1, 8'h0C, 8'h96, 1'b1, nb, rd, ne);
        check("lat15 write busy", nb, 16);
        access(15, 1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, nb, rd, ne);
        check("lat15 read busy", nb, 16);
        check("lat15 read data", {24'd0, rd}, 32'h96);

        repeat (2) @(posedge clock);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the controller's load/store interface. It receives MemRead/MemWrite requests and stalls the controller through busy.
- Contains a DEPTH-word NBITS-wide storage array with a configurable access latency. This models a slow data memory or cache behind the core.
- Sits between the datapath (Address/WriteData from the ALU/register file) and the controller (busy).

Parameters:
NBITS, 8, data and address width
DEPTH, 64, number of words in the array (power of 2)
LATENCY, 2, wait cycles per access; legal range 1..15

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
MemRead  input  1  read request, held stable by the initiator until busy is low
MemWrite  input  1  write request, held stable by the initiator until busy is low
Address  input  NBITS  byte address; word index = Address[NBITS-1:2] mod DEPTH
WriteData  input  NBITS  store data
busy  output  1  responder occupied; the initiator must stall
ReadData  output  NBITS  load result, registered
error  output  1  one-cycle pulse on an illegal request (MemRead and MemWrite both high)

Behaviour:
- Reset (asynchronous): state=IDLE, busy=0, ReadData=0, error=0, wait counter=0, latched request discarded.
- Reset does not clear array contents.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - busy = MemRead | MemWrite (combinational, same cycle as the request), so the controller stalls immediately.
  - On a clock edge with a request: latch word index, WriteData and kind (write if MemWrite, else read); counter <= LATENCY-1; go to WAIT.
- WAIT:
  - busy=1.
  - Each edge: if counter != 0, decrement it.
  - If counter == 0:
    - write: array[idx] <= latched data; ReadData unchanged.
    - read: ReadData <= array[idx].
    - Go to DONE.
  - Total stall = LATENCY+1 cycles, counting the request cycle.
- DONE:
  - busy=0 for exactly one cycle; ReadData valid.
  - Request inputs are ignored in this cycle: a still-asserted request is the completed one, not a new one.
  - Next edge: go to IDLE.
- Back-to-back: a request still asserted in IDLE after DONE is a new access.
- ReadData holds its value until the next completed read.
- Simultaneous MemRead & MemWrite in IDLE:
  - Treated as a write.
  - error pulses high for one cycle on the accept edge (registered).
- Address:
  - Low 2 bits are ignored.
  - Upper bits wrap modulo DEPTH; no fault is raised.
- Inputs changing during WAIT do not affect the access: the latched copy is used.
- Reset asserted in WAIT:
  - Pending write is not performed.
  - busy drops asynchronously.
  - FSM returns to IDLE.
- Write followed by a read of the same word returns the new data: no bypass is required because the accesses are serialized.

Test Plan:
- Reset → busy=0, ReadData=0, error=0. Then MemWrite, Address=0x08, WriteData=0xA5, LATENCY=2 → busy high 3 cycles, low in DONE. A read of 0x08 returns ReadData=0xA5 on its DONE cycle.
- Address aliasing (DEPTH=64): write 0x3C to Address=0x04, read Address=0x07 → 0x3C (low bits ignored). Write 0x11 to Address=0xFC, read 0xFC → 0x11.
- Request held through DONE: MemRead held 1 continuously → accesses complete every LATENCY+2 cycles. Each DONE has busy=0; no double-count within the DONE cycle.
- MemRead=MemWrite=1, Address=0x10, WriteData=0x5A → error pulses one cycle; word 0x10 becomes 0x5A; a later read returns 0x5A.
- Reset mid-operation:
  - Preload word 0x20=0x77.
  - Start write 0xFF to 0x20; assert reset during WAIT → busy=0 immediately, state IDLE.
  - Read of 0x20 returns 0x77.
- LATENCY=1 and LATENCY=15 builds: busy length = 2 and 16 cycles respectively. Change Address/WriteData mid-WAIT → stored data equals the originally latched values.
